serial_ripple_subtractor: RTL and testbench

//   Bit-serial counterpart to the combinational ripple-carry adder: computes A - B
//   one bit per clock through a single full-subtractor cell and a registered borrow.

---
 rtl/serial_ripple_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial A - B through one full-subtractor cell and a registered borrow.
// Optional signed-overflow flag output is enabled by defining OVERFLOW_FLAG_EN.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Diff
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH:0]   r_diff;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;

  // Single full-subtractor cell working on the current LSBs.
  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_br;
  assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  assign w_accept  = (r_state == StIdle) && start;
  assign w_last    = (r_state == StShift) && (r_cnt == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StShift;
        end
      end
      StShift: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= A;
      r_b_sr <= B;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == StShift) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Result register only moves on the final bit edge, so it holds through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
    end else if (w_last) begin
      r_diff <= {w_br_next, w_d, r_res[WIDTH-1:1]};
    end
  end

  assign Diff = r_diff;

`ifdef OVERFLOW_FLAG_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits are shifted out of the serial regs, so keep copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor: directed vectors, randomized ops
// against an arithmetic reference, start-while-busy, mid-op reset and back-to-back runs.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W:0]   Diff;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Reference: borrow is A<B, low bits are (A-B) mod 2^W.
  function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ua;
    int unsigned ub;
    int unsigned m;
    logic [W:0]  r;
    ua = a;
    ub = b;
    m  = 1 << W;
    r[W]     = (ua < ub);
    r[W-1:0] = W'((ua + m - ub) % m);
    return r;
  endfunction

  // Reference: signed difference falls outside the W-bit two's complement range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    return (d > (2 ** (W - 1)) - 1) || (d < -(2 ** (W - 1)));
  endfunction

  // Launch one op, scramble the inputs after acceptance, follow it until busy drops.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 4 * W + 8; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = i + 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (Diff !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_diff: got %b want 00000", Diff);
    end
`ifdef OVERFLOW_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{4'b0011, 4'b0001, 4'b1111};
    logic [W-1:0] vb [3] = '{4'b0001, 4'b1001, 4'b1000};
    logic [W:0]   vd [3] = '{5'b0_0010, 5'b1_1000, 5'b0_0111};
    int lat;
    int bc;
    int dc;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], lat, bc, dc);
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, W + 1);
      end
      checks++;
      if (bc != W + 1 || dc != 1) begin
        errors++;
        $display("FAIL dir_busy_done[%0d]: busy %0d done %0d want %0d/1", k, bc, dc, W + 1);
      end
      checks++;
      if (Diff !== vd[k]) begin
        errors++;
        $display("FAIL dir_diff[%0d]: got %b want %b", k, Diff, vd[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Diff !== vd[2] || busy !== 1'b0) begin
      errors++;
      $display("FAIL dir_hold_idle: diff %b busy %b want %b/0", Diff, busy, vd[2]);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int bc;
    int dc;
    int edges;
    run_op(4'b0011, 4'b0001, lat, bc, dc);
    @(negedge clk);
    A     = 4'b0001;
    B     = 4'b1001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    A     = 4'b0000;
    B     = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 2;
    checks++;
    if (Diff !== 5'b0_0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_prior_held: diff %b busy %b want 00010/1", Diff, busy);
    end
    while (!done && edges < 4 * W) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (!done || edges != W) begin
      errors++;
      $display("FAIL ign_latency: done %b edges %0d want 1/%0d", done, edges, W);
    end
    checks++;
    if (Diff !== 5'b1_1000) begin
      errors++;
      $display("FAIL ign_diff: got %b want 11000", Diff);
    end
    dc = 0;
    bc = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
      if (busy) bc++;
    end
    checks++;
    if (dc != 0 || bc != 0) begin
      errors++;
      $display("FAIL ign_not_queued: extra done %0d busy %0d want 0/0", dc, bc);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    int dc;
    @(negedge clk);
    A     = 4'b1111;
    B     = 4'b1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Diff !== 5'b0_0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy %b done %b diff %b want 0/0/00000", busy, done, Diff);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    bc = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
      if (busy) bc++;
    end
    checks++;
    if (dc != 0 || bc != 0 || Diff !== 5'b0_0000) begin
      errors++;
      $display("FAIL rst_mid_no_done: done %0d busy %0d diff %b want 0/0/00000", dc, bc, Diff);
    end
    run_op(4'b1111, 4'b1000, lat, bc, dc);
    checks++;
    if (lat != W + 1 || Diff !== 5'b0_0111) begin
      errors++;
      $display("FAIL rst_mid_recover: lat %0d diff %b want %0d/00111", lat, Diff, W + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int lat;
    int bc;
    int dc;
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      run_op(a, b, lat, bc, dc);
      checks++;
      if (lat != W + 1 || dc != 1 || Diff !== ref_diff(a, b)) begin
        errors++;
        $display("FAIL rand_op[%0d] %b-%b: diff %b lat %0d dones %0d want %b/%0d/1",
                 k, a, b, Diff, lat, dc, ref_diff(a, b), W + 1);
      end
`ifdef OVERFLOW_FLAG_EN
      checks++;
      if (ovf !== ref_ovf(a, b)) begin
        errors++;
        $display("FAIL rand_ovf[%0d] %b-%b: got %b want %b", k, a, b, ovf, ref_ovf(a, b));
      end
`endif
    end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_ovf();
    int lat;
    int bc;
    int dc;
    run_op(4'b0111, 4'b1000, lat, bc, dc);
    checks++;
    if (Diff !== 5'b1_1111 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: diff %b ovf %b want 11111/1", Diff, ovf);
    end
    run_op(4'b0011, 4'b0010, lat, bc, dc);
    checks++;
    if (Diff !== 5'b0_0001 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: diff %b ovf %b want 00001/0", Diff, ovf);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int n_done;
    int last_cyc;
    int cyc;
    @(negedge clk);
    A = W'($urandom);
    B = W'($urandom);
    qa.push_back(A);
    qb.push_back(B);
    start    = 1'b1;
    n_done   = 0;
    last_cyc = -1;
    cyc      = 0;
    while (n_done < 5 && cyc < 20 * (W + 2)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        checks++;
        if (Diff !== ref_diff(ea, eb)) begin
          errors++;
          $display("FAIL b2b_diff[%0d] %b-%b: got %b want %b", n_done, ea, eb, Diff,
                   ref_diff(ea, eb));
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n_done, cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        n_done++;
        if (n_done == 5) begin
          start = 1'b0;
        end else begin
          A = W'($urandom);
          B = W'($urandom);
          qa.push_back(A);
          qb.push_back(B);
        end
      end else if (busy) begin
        // Scramble while shifting; the pending pair is reloaded at the next done.
        A = W'($urandom);
        B = W'($urandom);
      end
    end
    checks++;
    if (n_done != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 5", n_done);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random();
`ifdef OVERFLOW_FLAG_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
